phys_free_list: RTL and testbench

- Circular free list of physical register tags; supplies the destination tag the rename table writes on rename.
- Takes back the previous mapping of an architectural register when its overwriting instruction commits.
- Keeps a committed head pointer so that a pipeline flush restores every speculatively allocated tag in one cycle.
- Sits beside the rename table in the rename stage; free and commit inputs come from the ROB retire port.

---
 rtl/phys_free_list.sv | 164 ++++++++++++++++
 tb/tb_phys_free_list.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// phys_free_list: circular free list of physical register tags for the rename stage.
// Allocation pops the head, commit-time frees push at the tail, and a committed
// head pointer lets a flush hand back every speculative allocation in one cycle.
// Optional protocol checking is built when FREELIST_CHECK_EN is defined; otherwise
// err is tied low and no checking logic exists.
//
// Handshake: alloc_valid is the ready/valid indication for rename. A grant happens
// exactly when alloc_req && alloc_valid on a rising edge; alloc_phys_rd is
// combinational from the head entry and is latched by the consumer on that edge.
// free_en / commit_en are single-cycle pulses with no back-pressure.
module phys_free_list #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    localparam int PW    = $clog2(NUM_PHYS),
    localparam int DEPTH = NUM_PHYS - NUM_ARCH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc_req,
    output logic          alloc_valid,
    output logic [PW-1:0] alloc_phys_rd,
    input  logic          free_en,
    input  logic [PW-1:0] free_phys_rd,
    input  logic          commit_en,
    input  logic          flush,
    output logic [CW-1:0] free_count,
    output logic          full,
    output logic          empty,
    output logic          err
);

    // DEPTH must be a power of two: pointers wrap by natural overflow.

    logic [PW-1:0] r_entry [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW-1:0] r_commit_head;
    logic [CW-1:0] r_free_count;
    logic [CW-1:0] r_inflight;

    logic          w_alloc_fire;
    logic          w_free_ok;
    logic          w_commit_ok;
    logic [AW-1:0] w_commit_head_nxt;
    logic [CW-1:0] w_inflight_cmt;

    assign full          = (r_free_count == CW'(DEPTH));
    assign empty         = (r_free_count == '0);
    assign free_count    = r_free_count;
    assign alloc_valid   = !empty && !flush;
    assign alloc_phys_rd = r_entry[r_head];

    // A grant that leaves the list in the same cycle makes room for a free,
    // so a full list still accepts a free when an allocation fires alongside it.
    assign w_alloc_fire  = alloc_req && alloc_valid;
    assign w_free_ok     = free_en && (!full || w_alloc_fire);
    assign w_commit_ok   = commit_en && (r_inflight != '0);

    // Commit is applied before a flush restore in the same cycle.
    assign w_commit_head_nxt = r_commit_head + AW'(w_commit_ok);
    assign w_inflight_cmt    = r_inflight - CW'(w_commit_ok);

    // Tag storage: reset maps the upper tags into the list; frees write at tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= PW'(NUM_ARCH + i);
            end
        end else if (w_free_ok) begin
            r_entry[r_tail] <= free_phys_rd;
        end
    end

    // Tail pointer advances on every accepted free, flush or not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tail <= '0;
        end else if (w_free_ok) begin
            r_tail <= r_tail + AW'(1);
        end
    end

    // Committed head tracks retired allocations; it is the flush restore point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_commit_head <= '0;
        end else begin
            r_commit_head <= w_commit_head_nxt;
        end
    end

    // Speculative head: advances on grant, snaps back to the committed head on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head <= '0;
        end else if (flush) begin
            r_head <= w_commit_head_nxt;
        end else begin
            r_head <= r_head + AW'(w_alloc_fire);
        end
    end

    // Free count and in-flight count; a flush returns all uncommitted tags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_free_count <= CW'(DEPTH);
            r_inflight   <= '0;
        end else if (flush) begin
            r_free_count <= r_free_count + CW'(w_free_ok) + w_inflight_cmt;
            r_inflight   <= '0;
        end else begin
            r_free_count <= r_free_count + CW'(w_free_ok) - CW'(w_alloc_fire);
            r_inflight   <= w_inflight_cmt + CW'(w_alloc_fire);
        end
    end

`ifdef FREELIST_CHECK_EN
    logic [AW-1:0] w_off [DEPTH];
    logic          w_double_free;
    logic          w_err_set;
    logic          r_err;

    // Distance of each slot from the head; slots with distance < free_count hold free tags.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i] = AW'(i) - r_head;
        end
    end

    // Double free: the returned tag already sits in the free region. The head slot
    // is excluded when it is being granted this cycle, since that tag is leaving.
    always_comb begin
        w_double_free = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, w_off[i]} < r_free_count) &&
                !(w_alloc_fire && (w_off[i] == '0)) &&
                (r_entry[i] == free_phys_rd)) begin
                w_double_free = 1'b1;
            end
        end
    end

    assign w_err_set = (free_en && full && !w_alloc_fire) ||
                       (commit_en && (r_inflight == '0)) ||
                       (alloc_req && !alloc_valid && !flush) ||
                       (free_en && w_double_free);

    // Sticky protocol error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Directed testbench for phys_free_list. Inputs change on the falling edge,
// outputs are sampled 1ns later, well away from the rising edge.
module tb_phys_free_list;

    logic       clk;
    logic       reset;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_phys_rd;
    logic       free_en;
    logic [5:0] free_phys_rd;
    logic       commit_en;
    logic       flush;
    logic [5:0] free_count;
    logic       full;
    logic       empty;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    phys_free_list #(.NUM_PHYS(64), .NUM_ARCH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_phys_rd(alloc_phys_rd),
        .free_en      (free_en),
        .free_phys_rd (free_phys_rd),
        .commit_en    (commit_en),
        .flush        (flush),
        .free_count   (free_count),
        .full         (full),
        .empty        (empty),
        .err          (err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        alloc_req    = 1'b0;
        free_en      = 1'b0;
        free_phys_rd = '0;
        commit_en    = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (alloc_phys_rd !== 6'd32 || free_count !== 6'd32 || full !== 1'b1 ||
            empty !== 1'b0 || err !== 1'b0 || alloc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: tag=%0d cnt=%0d full=%b empty=%b err=%b valid=%b expected 32 32 1 0 0 1",
                     alloc_phys_rd, free_count, full, empty, err, alloc_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_tag;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            alloc_req = 1'b1;
            #1;
            exp_tag = 6'd32 + 6'(i);
            n_tests++;
            if (alloc_phys_rd !== exp_tag || alloc_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_grant%0d: tag=%0d valid=%b expected tag=%0d valid=1",
                         i, alloc_phys_rd, alloc_valid, exp_tag);
            end
        end
        @(negedge clk);
        alloc_req = 1'b0;
        #1;
        n_tests++;
        if (free_count !== 6'd29 || alloc_phys_rd !== 6'd35 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_after: cnt=%0d tag=%0d full=%b expected 29 35 0",
                     free_count, alloc_phys_rd, full);
        end
    endtask

    task automatic test_empty_refill();
        logic [5:0] exp_tag;
        int         bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            alloc_req = 1'b1;
            #1;
            exp_tag = 6'd32 + 6'(i);
            if (alloc_phys_rd !== exp_tag) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL drain_tags: %0d of 32 grants wrong, expected 0 wrong", bad);
        end
        @(negedge clk);
        alloc_req = 1'b0;
        #1;
        n_tests++;
        if (empty !== 1'b1 || alloc_valid !== 1'b0 || free_count !== 6'd0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL drained: empty=%b valid=%b cnt=%0d full=%b expected 1 0 0 0",
                     empty, alloc_valid, free_count, full);
        end
        @(negedge clk);
        free_en      = 1'b1;
        free_phys_rd = 6'd2;
        #1;
        n_tests++;
        if (alloc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: valid=%b expected 0", alloc_valid);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++;
        if (alloc_valid !== 1'b1 || alloc_phys_rd !== 6'd2 || free_count !== 6'd1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL refill: valid=%b tag=%0d cnt=%0d empty=%b expected 1 2 1 0",
                     alloc_valid, alloc_phys_rd, free_count, empty);
        end
    endtask

    task automatic test_flush_restore();
        do_reset();
        repeat (4) begin
            @(negedge clk);
            alloc_req = 1'b1;
        end
        @(negedge clk);
        alloc_req = 1'b0;
        commit_en = 1'b1;
        @(negedge clk);
        commit_en = 1'b1;
        @(negedge clk);
        commit_en = 1'b0;
        flush     = 1'b1;
        alloc_req = 1'b1;
        #1;
        n_tests++;
        if (alloc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_valid: valid=%b expected 0", alloc_valid);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++;
        if (alloc_phys_rd !== 6'd34 || free_count !== 6'd30 || alloc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_restore: tag=%0d cnt=%0d valid=%b expected 34 30 1",
                     alloc_phys_rd, free_count, alloc_valid);
        end
        // A second bare flush must not return anything: nothing is in flight.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_tests++;
        if (alloc_phys_rd !== 6'd34 || free_count !== 6'd30) begin
            n_fail++;
            $display("FAIL flush_idle: tag=%0d cnt=%0d expected 34 30", alloc_phys_rd, free_count);
        end
    endtask

    task automatic test_flush_commit_free();
        do_reset();
        repeat (4) begin
            @(negedge clk);
            alloc_req = 1'b1;
        end
        @(negedge clk);
        alloc_req = 1'b0;
        commit_en = 1'b1;
        @(negedge clk);
        flush        = 1'b1;
        commit_en    = 1'b1;
        free_en      = 1'b1;
        free_phys_rd = 6'd5;
        alloc_req    = 1'b1;
        #1;
        n_tests++;
        if (alloc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fcf_valid: valid=%b expected 0", alloc_valid);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++;
        if (free_count !== 6'd31 || alloc_phys_rd !== 6'd34 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL fcf_restore: cnt=%0d tag=%0d err=%b expected 31 34 0",
                     free_count, alloc_phys_rd, err);
        end
    endtask

    task automatic test_wrap();
        logic [5:0] exp_tag;
        logic       exp_err;
        int         bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            alloc_req    = 1'b1;
            free_en      = 1'b1;
            free_phys_rd = 6'(i);
            #1;
            exp_tag = (i < 32) ? 6'(32 + i) : 6'(i - 32);
            if (alloc_phys_rd !== exp_tag || alloc_valid !== 1'b1) begin
                bad++;
                $display("FAIL wrap_grant%0d: tag=%0d valid=%b expected tag=%0d valid=1",
                         i, alloc_phys_rd, alloc_valid, exp_tag);
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++;
        if (free_count !== 6'd32 || full !== 1'b1 || alloc_phys_rd !== 6'd8 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_after: cnt=%0d full=%b tag=%0d err=%b expected 32 1 8 0",
                     free_count, full, alloc_phys_rd, err);
        end
        // Free into a full list: suppressed; flagged when checking is built in.
`ifdef FREELIST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        @(negedge clk);
        free_en      = 1'b1;
        free_phys_rd = 6'd50;
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++;
        if (free_count !== 6'd32 || alloc_phys_rd !== 6'd8 || err !== exp_err) begin
            n_fail++;
            $display("FAIL full_free: cnt=%0d tag=%0d err=%b expected 32 8 %b",
                     free_count, alloc_phys_rd, err, exp_err);
        end
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b expected %b", err, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) begin
            @(negedge clk);
            alloc_req = 1'b1;
        end
        @(negedge clk);
        alloc_req = 1'b1;
        free_en   = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (alloc_phys_rd !== 6'd32 || free_count !== 6'd32 || full !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: tag=%0d cnt=%0d full=%b err=%b expected 32 32 1 0",
                     alloc_phys_rd, free_count, full, err);
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        #1;
        n_tests++;
        if (alloc_phys_rd !== 6'd32 || free_count !== 6'd32 || alloc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_release: tag=%0d cnt=%0d valid=%b expected 32 32 1",
                     alloc_phys_rd, free_count, alloc_valid);
        end
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_empty_refill();
        test_flush_restore();
        test_flush_commit_free();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
